// File: rtl/axi_sram_pkg.sv
// Shared encodings and address helpers for the AXI4-to-SRAM bridge.
package axi_sram_pkg;

  localparam int         WORD_BYTES  = 8;
  localparam logic [2:0] SIZE_WORD   = 3'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_BURST,
    RD_DRAIN
  } state_e;

  // Decode error beats slave error when both apply.
  function automatic logic [1:0] addr_resp(input logic [31:0] addr,
                                           input logic [2:0]  size,
                                           input logic [1:0]  burst);
    if (addr[31:12] != 20'd0) return RESP_DECERR;
    if (size != SIZE_WORD || burst == BURST_WRAP || burst == 2'b11) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // INCR stays inside the 4 KiB window; FIXED repeats the same word.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  burst);
    if (burst == BURST_INCR) return {addr[31:12], addr[11:0] + 12'(WORD_BYTES)};
    return addr;
  endfunction

endpackage

// File: rtl/axi_sram_rd_buf.sv
// Two-entry read-data FIFO holding {RLAST, RDATA} between the SRAM and the R channel.
module axi_sram_rd_buf #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  output logic [1:0]    count_o
);

  logic [DW:0] mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {last_i, data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign {last_o, data_o} = mem_q[rd_ptr_q];
  assign count_o          = count_q;

endmodule

// File: rtl/axi_sram_bridge.sv
// AXI4 slave serialising INCR/FIXED bursts onto a single-port active-low SRAM bus.
module axi_sram_bridge
  import axi_sram_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic [ID_W-1:0] AWID,
  input  logic [31:0]     AWADDR,
  input  logic [7:0]      AWLEN,
  input  logic [2:0]      AWSIZE,
  input  logic [1:0]      AWBURST,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [63:0]     WDATA,
  input  logic [7:0]      WSTRB,
  input  logic            WLAST,
  input  logic            WVALID,
  output logic            WREADY,
  output logic [ID_W-1:0] BID,
  output logic [1:0]      BRESP,
  output logic            BVALID,
  input  logic            BREADY,
  input  logic [ID_W-1:0] ARID,
  input  logic [31:0]     ARADDR,
  input  logic [7:0]      ARLEN,
  input  logic [2:0]      ARSIZE,
  input  logic [1:0]      ARBURST,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [ID_W-1:0] RID,
  output logic [63:0]     RDATA,
  output logic [1:0]      RRESP,
  output logic            RLAST,
  output logic            RVALID,
  input  logic            RREADY,
  output logic            SRAM_CEn,
  output logic [31:0]     SRAM_ADDR,
  output logic [63:0]     SRAM_WDATA,
  output logic            SRAM_WEn,
  output logic [7:0]      SRAM_WBEn,
  input  logic [63:0]     SRAM_RDATA
);

  state_e          state_q, state_d;
  logic            prio_wr_q, prio_wr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      beat_q, beat_d;
  logic [1:0]      burst_q, burst_d;
  logic            err_q, err_d;
  logic [1:0]      resp_q, resp_d;
  logic            infl_q, infl_d;
  logic            infl_last_q, infl_last_d;
  logic [31:0]     hold_addr_q;
  logic [63:0]     hold_wdata_q;

  logic [1:0]      rb_count;
  logic            rb_pop;
  logic [2:0]      occ;

  assign RVALID = RESETn && (rb_count != 2'd0);
  assign rb_pop = RVALID && RREADY;
  // Slots committed after this cycle's pop: buffered plus the strobe whose data lands next.
  assign occ    = {1'b0, rb_count} + {2'b0, infl_q} - {2'b0, rb_pop};

  axi_sram_rd_buf #(.DW(64)) u_rd_buf (
    .clk     (CLK),
    .rst_n   (RESETn),
    .push_i  (infl_q),
    .data_i  (err_q ? 64'd0 : SRAM_RDATA),
    .last_i  (infl_last_q),
    .pop_i   (rb_pop),
    .data_o  (RDATA),
    .last_o  (RLAST),
    .count_o (rb_count)
  );

  assign BID   = id_q;
  assign RID   = id_q;
  assign BRESP = resp_q;
  assign RRESP = resp_q;

  always_comb begin
    state_d     = state_q;
    prio_wr_d   = prio_wr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    burst_d     = burst_q;
    err_d       = err_q;
    resp_d      = resp_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    AWREADY     = 1'b0;
    ARREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    SRAM_CEn    = 1'b1;
    SRAM_WEn    = 1'b1;
    SRAM_WBEn   = 8'hFF;
    SRAM_ADDR   = hold_addr_q;
    SRAM_WDATA  = hold_wdata_q;

    case (state_q)
      IDLE: begin
        // Only the favoured channel sees READY on a tie, so one handshake per cycle.
        AWREADY = !ARVALID || prio_wr_q;
        ARREADY = !AWVALID || !prio_wr_q;
        if (AWVALID && AWREADY) begin
          id_d      = AWID;
          addr_d    = AWADDR & 32'hFFFF_FFF8;
          len_d     = AWLEN;
          burst_d   = AWBURST;
          resp_d    = addr_resp(AWADDR, AWSIZE, AWBURST);
          err_d     = (addr_resp(AWADDR, AWSIZE, AWBURST) != RESP_OKAY);
          beat_d    = 8'd0;
          prio_wr_d = 1'b0;
          state_d   = WR_DATA;
        end else if (ARVALID && ARREADY) begin
          id_d      = ARID;
          addr_d    = ARADDR & 32'hFFFF_FFF8;
          len_d     = ARLEN;
          burst_d   = ARBURST;
          resp_d    = addr_resp(ARADDR, ARSIZE, ARBURST);
          err_d     = (addr_resp(ARADDR, ARSIZE, ARBURST) != RESP_OKAY);
          beat_d    = 8'd0;
          prio_wr_d = 1'b1;
          state_d   = RD_BURST;
        end
      end

      WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          if (!err_q) begin
            SRAM_CEn   = 1'b0;
            SRAM_WEn   = 1'b0;
            SRAM_ADDR  = addr_q;
            SRAM_WDATA = WDATA;
            SRAM_WBEn  = ~WSTRB;
            if (WLAST != (beat_q == len_q)) resp_d = RESP_SLVERR;
          end
          if (beat_q == len_q) begin
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = next_addr(addr_q, burst_q);
          end
        end
      end

      WR_RESP: begin
        BVALID = 1'b1;
        if (BREADY) state_d = IDLE;
      end

      RD_BURST: begin
        if (occ < 3'd2) begin
          infl_d      = 1'b1;
          infl_last_d = (beat_q == len_q);
          if (!err_q) begin
            SRAM_CEn  = 1'b0;
            SRAM_ADDR = addr_q;
          end
          if (beat_q == len_q) begin
            state_d = RD_DRAIN;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = next_addr(addr_q, burst_q);
          end
        end
      end

      RD_DRAIN: begin
        if (occ == 3'd0) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (!RESETn) begin
      AWREADY   = 1'b0;
      ARREADY   = 1'b0;
      WREADY    = 1'b0;
      BVALID    = 1'b0;
      SRAM_CEn  = 1'b1;
      SRAM_WEn  = 1'b1;
      SRAM_WBEn = 8'hFF;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q      <= IDLE;
      prio_wr_q    <= 1'b1;
      id_q         <= '0;
      addr_q       <= 32'd0;
      len_q        <= 8'd0;
      beat_q       <= 8'd0;
      burst_q      <= BURST_FIXED;
      err_q        <= 1'b0;
      resp_q       <= RESP_OKAY;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      hold_addr_q  <= 32'd0;
      hold_wdata_q <= 64'd0;
    end else begin
      state_q      <= state_d;
      prio_wr_q    <= prio_wr_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      burst_q      <= burst_d;
      err_q        <= err_d;
      resp_q       <= resp_d;
      infl_q       <= infl_d;
      infl_last_q  <= infl_last_d;
      hold_addr_q  <= SRAM_ADDR;
      hold_wdata_q <= SRAM_WDATA;
    end
  end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed bench for axi_sram_bridge with a behavioural 1-cycle-latency SRAM.
module tb_axi_sram_bridge;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, SRAM_ADDR;
  logic [7:0]  AWLEN, ARLEN, WSTRB, SRAM_WBEn;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, SRAM_CEn, SRAM_WEn;
  logic [63:0] WDATA, RDATA, SRAM_WDATA, SRAM_RDATA;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  axi_sram_bridge #(.ID_W(4)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .SRAM_CEn(SRAM_CEn), .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA),
    .SRAM_WEn(SRAM_WEn), .SRAM_WBEn(SRAM_WBEn), .SRAM_RDATA(SRAM_RDATA)
  );

  function automatic logic [63:0] pat(input int i);
    return {16'hC0DE, i[15:0], i[7:0], i[7:0], i[7:0], i[7:0]};
  endfunction

  // SRAM model plus an append-only log of every strobe.
  bit          init_done;
  logic [63:0] mem [512];
  logic [31:0] log_addr[$];
  logic        log_we[$];

  always @(posedge CLK) begin
    if (!init_done) begin
      for (int i = 0; i < 512; i++) mem[i] <= pat(i);
      init_done <= 1'b1;
    end else if (!SRAM_CEn) begin
      log_addr.push_back(SRAM_ADDR);
      log_we.push_back(SRAM_WEn);
      if (!SRAM_WEn) begin
        for (int b = 0; b < 8; b++)
          if (!SRAM_WBEn[b]) mem[SRAM_ADDR[11:3]][8*b +: 8] <= SRAM_WDATA[8*b +: 8];
      end else begin
        SRAM_RDATA <= mem[SRAM_ADDR[11:3]];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  logic [63:0] rd_dat [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  int          rd_n;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 3; AWBURST = 1;
    ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 3; ARBURST = 1;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0; RREADY = 0;
  endtask

  task automatic apply_reset();
    RESETn = 0; idle_inputs();
    tick(); tick(); tick();
    RESETn = 1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
    AWID = id; AWADDR = a; AWLEN = len; AWSIZE = 3; AWBURST = burst; AWVALID = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (AWREADY) begin tick(); AWVALID = 0; return; end
    end
    n_vec++; n_err++; $display("FAIL aw_timeout got AWREADY=0 need 1 within 20 cycles");
    tick(); AWVALID = 0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
    ARID = id; ARADDR = a; ARLEN = len; ARSIZE = 3; ARBURST = burst; ARVALID = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ARREADY) begin tick(); ARVALID = 0; return; end
    end
    n_vec++; n_err++; $display("FAIL ar_timeout got ARREADY=0 need 1 within 20 cycles");
    tick(); ARVALID = 0;
  endtask

  task automatic w_beats(input int len, input bit early);
    for (int b = 0; b <= len; b++) begin
      WDATA = pat(100 + b); WSTRB = 8'hFF; WLAST = early || (b == len); WVALID = 1;
      begin : wait_w
        for (int i = 0; i < 20; i++) begin
          @(negedge CLK);
          if (WREADY) disable wait_w;
        end
        n_vec++; n_err++; $display("FAIL w_timeout beat %0d got WREADY=0 need 1", b);
      end
      tick();
    end
    WVALID = 0; WLAST = 0;
  endtask

  task automatic b_wait(output logic [1:0] resp);
    BREADY = 1;
    resp = 2'bxx;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (BVALID) begin resp = BRESP; tick(); BREADY = 0; return; end
    end
    n_vec++; n_err++; $display("FAIL b_timeout got BVALID=0 need 1 within 20 cycles");
    tick(); BREADY = 0;
  endtask

  task automatic r_collect();
    rd_n = 0; RREADY = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (RVALID) begin
        if (rd_n < 16) begin rd_dat[rd_n] = RDATA; rd_resp[rd_n] = RRESP; rd_last[rd_n] = RLAST; end
        rd_n++;
        if (RLAST) begin tick(); RREADY = 0; return; end
      end
      tick();
    end
    n_vec++; n_err++; $display("FAIL r_timeout got no RLAST need one within 40 cycles");
    RREADY = 0;
  endtask

  task automatic test_reset();
    RESETn = 0; idle_inputs();
    tick(); tick();
    @(negedge CLK);
    n_vec++; if ({AWREADY, ARREADY, SRAM_CEn} !== 3'b001) begin n_err++;
      $display("FAIL rst_held got rdy/cen=%b need 001", {AWREADY, ARREADY, SRAM_CEn}); end
    tick(); RESETn = 1;
    @(negedge CLK);
    n_vec++; if ({AWREADY, ARREADY, WREADY, BVALID, RVALID} !== 5'b11000) begin n_err++;
      $display("FAIL rst_handshake got %b need 11000", {AWREADY, ARREADY, WREADY, BVALID, RVALID}); end
    n_vec++; if ({SRAM_CEn, SRAM_WEn, SRAM_WBEn} !== 10'b11_1111_1111) begin n_err++;
      $display("FAIL rst_sram_ctl got %b need 1111111111", {SRAM_CEn, SRAM_WEn, SRAM_WBEn}); end
    n_vec++; if ({SRAM_ADDR, SRAM_WDATA} !== 96'd0) begin n_err++;
      $display("FAIL rst_sram_bus got %h/%h need 0/0", SRAM_ADDR, SRAM_WDATA); end
    tick();
  endtask

  task automatic test_single_write();
    AWID = 5; AWADDR = 32'h008; AWLEN = 0; AWSIZE = 3; AWBURST = 1; AWVALID = 1;
    @(negedge CLK);
    n_vec++; if (AWREADY !== 1'b1) begin n_err++; $display("FAIL wr1_awready got %b need 1", AWREADY); end
    tick(); AWVALID = 0;
    WDATA = 64'h1122334455667788; WSTRB = 8'h0F; WLAST = 1; WVALID = 1;
    @(negedge CLK);
    n_vec++; if ({WREADY, SRAM_CEn, SRAM_WEn, SRAM_ADDR, SRAM_WBEn} !== {3'b100, 32'h008, 8'hF0}) begin
      n_err++; $display("FAIL wr1_strobe got wr=%b cen=%b wen=%b addr=%h wben=%h need 1 0 0 00000008 f0",
                        WREADY, SRAM_CEn, SRAM_WEn, SRAM_ADDR, SRAM_WBEn); end
    n_vec++; if (SRAM_WDATA !== 64'h1122334455667788) begin n_err++;
      $display("FAIL wr1_wdata got %h need 1122334455667788", SRAM_WDATA); end
    tick(); WVALID = 0; WLAST = 0; BREADY = 1;
    @(negedge CLK);
    n_vec++; if ({BVALID, BRESP, BID, SRAM_CEn} !== {1'b1, 2'b00, 4'd5, 1'b1}) begin n_err++;
      $display("FAIL wr1_bresp got bvalid=%b bresp=%b bid=%0d cen=%b need 1 00 5 1", BVALID, BRESP, BID, SRAM_CEn); end
    tick(); BREADY = 0;
    n_vec++; if (mem[1] !== 64'hC0DE0001_55667788) begin n_err++;
      $display("FAIL wr1_mem got %h need c0de000155667788", mem[1]); end
  endtask

  task automatic test_read_incr();
    ARID = 3; ARADDR = 32'h200; ARLEN = 3; ARSIZE = 3; ARBURST = 1; ARVALID = 1; RREADY = 1;
    @(negedge CLK);
    n_vec++; if (ARREADY !== 1'b1) begin n_err++; $display("FAIL rd_arready got %b need 1", ARREADY); end
    tick(); ARVALID = 0;
    for (int k = 1; k <= 8; k++) begin
      logic exp_cen, exp_rv;
      @(negedge CLK);
      exp_cen = !(k <= 4);
      exp_rv  = (k >= 3) && (k <= 6);
      n_vec++; if (SRAM_CEn !== exp_cen || (!exp_cen && (SRAM_ADDR !== 32'h200 + 32'(8*(k-1)) || SRAM_WEn !== 1'b1))) begin
        n_err++; $display("FAIL rd_strobe c%0d got cen=%b wen=%b addr=%h need cen=%b addr=%h",
                          k, SRAM_CEn, SRAM_WEn, SRAM_ADDR, exp_cen, 32'h200 + 32'(8*(k-1))); end
      n_vec++; if (RVALID !== exp_rv) begin n_err++;
        $display("FAIL rd_rvalid c%0d got %b need %b", k, RVALID, exp_rv); end
      if (exp_rv) begin
        n_vec++; if ({RDATA, RLAST, RRESP, RID} !== {pat(64 + k - 3), (k == 6), 2'b00, 4'd3}) begin n_err++;
          $display("FAIL rd_beat c%0d got %h last=%b resp=%b id=%0d need %h last=%b", k, RDATA, RLAST, RRESP, RID,
                   pat(64 + k - 3), (k == 6)); end
      end
      if (k == 7) begin
        n_vec++; if (ARREADY !== 1'b1) begin n_err++; $display("FAIL rd_done_arready got %b need 1", ARREADY); end
      end
      tick();
    end
    RREADY = 0;
  endtask

  task automatic test_read_stall();
    int s, got, max_pend;
    logic stalled;
    logic [63:0] held_d;
    logic held_l;
    bit bad_stable, bad_order;
    s = log_addr.size(); got = 0; max_pend = 0; stalled = 0; bad_stable = 0; bad_order = 0;
    held_d = '0; held_l = 0;
    RREADY = 1;
    send_ar(6, 32'h200, 3, 2'b01);
    for (int k = 1; k <= 30; k++) begin
      RREADY = !(k == 4 || k == 5);
      @(negedge CLK);
      if (log_addr.size() - s - got > max_pend) max_pend = log_addr.size() - s - got;
      if (stalled && (RVALID !== 1'b1 || RDATA !== held_d || RLAST !== held_l)) bad_stable = 1;
      stalled = 0;
      if (RVALID === 1'b1) begin
        if (RREADY) begin
          if (RDATA !== pat(64 + got) || RLAST !== (got == 3)) bad_order = 1;
          got++;
        end else begin
          stalled = 1; held_d = RDATA; held_l = RLAST;
        end
      end
      tick();
      if (got == 4) break;
    end
    RREADY = 0;
    n_vec++; if (got !== 4) begin n_err++; $display("FAIL stall_beats got %0d need 4", got); end
    n_vec++; if (bad_order) begin n_err++; $display("FAIL stall_order got out-of-order data need pat(64..67)"); end
    n_vec++; if (bad_stable) begin n_err++; $display("FAIL stall_stable got changing R payload need stable"); end
    n_vec++; if (max_pend > 2) begin n_err++; $display("FAIL stall_outstanding got %0d need <=2", max_pend); end
    n_vec++; if (log_addr.size() - s !== 4 || log_addr[s+3] !== 32'h218) begin n_err++;
      $display("FAIL stall_strobes got %0d strobes need 4 ending at 218", log_addr.size() - s); end
  endtask

  task automatic test_errors();
    int s;
    logic [1:0] r;
    s = log_addr.size();
    send_ar(9, 32'h1000, 1, 2'b01);
    r_collect();
    n_vec++; if (rd_n !== 2 || rd_last[1] !== 1'b1 || rd_last[0] !== 1'b0) begin n_err++;
      $display("FAIL decerr_beats got %0d beats need 2 with RLAST on second", rd_n); end
    n_vec++; if ({rd_dat[0], rd_dat[1], rd_resp[0], rd_resp[1]} !== {128'd0, 4'b1111}) begin n_err++;
      $display("FAIL decerr_payload got %h %h resp %b %b need 0 0 11 11", rd_dat[0], rd_dat[1], rd_resp[0], rd_resp[1]); end
    send_aw(4, 32'h010, 0, 2'b10);
    w_beats(0, 0);
    b_wait(r);
    n_vec++; if (r !== 2'b10) begin n_err++; $display("FAIL wrap_bresp got %b need 10", r); end
    n_vec++; if (log_addr.size() !== s || mem[2] !== pat(2)) begin n_err++;
      $display("FAIL err_no_sram got %0d strobes need 0", log_addr.size() - s); end
  endtask

  task automatic test_wlast();
    int s;
    logic [1:0] r;
    s = log_addr.size();
    send_aw(2, 32'h050, 1, 2'b01);
    w_beats(1, 1);
    b_wait(r);
    n_vec++; if (r !== 2'b10) begin n_err++; $display("FAIL wlast_early got %b need 10", r); end
    n_vec++; if (log_addr.size() - s !== 2) begin n_err++;
      $display("FAIL wlast_beats got %0d writes need 2", log_addr.size() - s); end
  endtask

  task automatic test_fixed_write();
    int s;
    logic [1:0] r;
    bit bad;
    s = log_addr.size(); bad = 0;
    send_aw(1, 32'h100, 2, 2'b00);
    w_beats(2, 0);
    b_wait(r);
    n_vec++; if (r !== 2'b00) begin n_err++; $display("FAIL fixed_bresp got %b need 00", r); end
    for (int i = s; i < log_addr.size(); i++) if (log_addr[i] !== 32'h100 || log_we[i] !== 1'b0) bad = 1;
    n_vec++; if (log_addr.size() - s !== 3 || bad) begin n_err++;
      $display("FAIL fixed_strobes got %0d writes bad=%b need 3 at 100", log_addr.size() - s, bad); end
    n_vec++; if (mem[32] !== pat(102)) begin n_err++; $display("FAIL fixed_mem got %h need %h", mem[32], pat(102)); end
  endtask

  task automatic test_arbitration();
    logic [1:0] r;
    apply_reset();
    AWID = 1; AWADDR = 32'h030; AWLEN = 0; AWSIZE = 3; AWBURST = 1; AWVALID = 1;
    ARID = 2; ARADDR = 32'h040; ARLEN = 0; ARSIZE = 3; ARBURST = 1; ARVALID = 1;
    @(negedge CLK);
    n_vec++; if ({AWREADY, ARREADY} !== 2'b10) begin n_err++;
      $display("FAIL arb_first got aw/ar=%b need 10", {AWREADY, ARREADY}); end
    tick(); AWVALID = 0;
    w_beats(0, 0);
    b_wait(r);
    AWID = 1; AWADDR = 32'h038; AWVALID = 1;
    @(negedge CLK);
    n_vec++; if ({AWREADY, ARREADY} !== 2'b01) begin n_err++;
      $display("FAIL arb_second got aw/ar=%b need 01", {AWREADY, ARREADY}); end
    tick(); ARVALID = 0;
    r_collect();
    n_vec++; if (rd_n !== 1 || rd_dat[0] !== pat(8)) begin n_err++;
      $display("FAIL arb_read got %0d beats data %h need 1 beat %h", rd_n, rd_dat[0], pat(8)); end
    send_aw(1, 32'h038, 0, 2'b01);
    w_beats(0, 0);
    b_wait(r);
    n_vec++; if (r !== 2'b00) begin n_err++; $display("FAIL arb_write2 got %b need 00", r); end
  endtask

  task automatic test_reset_mid_burst();
    int s, stray;
    RREADY = 1;
    send_ar(7, 32'h200, 3, 2'b01);
    tick(); tick(); tick();
    RESETn = 0;
    tick();
    RESETn = 1;
    @(negedge CLK);
    n_vec++; if ({RVALID, SRAM_CEn, ARREADY} !== 3'b011) begin n_err++;
      $display("FAIL midrst_state got rvalid/cen/arready=%b need 011", {RVALID, SRAM_CEn, ARREADY}); end
    s = log_addr.size(); stray = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge CLK);
      if (RVALID !== 1'b0) stray++;
    end
    tick();
    n_vec++; if (stray != 0 || log_addr.size() !== s) begin n_err++;
      $display("FAIL midrst_stale got %0d beats %0d strobes need 0 0", stray, log_addr.size() - s); end
    RREADY = 0;
  endtask

  initial begin
    idle_inputs();
    RESETn = 0;
    SRAM_RDATA = '0;
    test_reset();
    test_single_write();
    test_read_incr();
    test_read_stall();
    test_errors();
    test_wlast();
    test_fixed_write();
    test_arbitration();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_sram_bridge.md
# axi_sram_bridge

AXI4 slave that converts burst transactions from the system interconnect into the single-port, active-low SRAM-style bus used by the GCD argument/result register file (ARG_A/ARG_B, BEZOUT, DEBUG windows; 4 KiB window, 64-bit words, 1-cycle read latency). It sits directly upstream of that register file in the GCD wrapper. It serialises reads and writes onto the one SRAM port, walks INCR/FIXED bursts, and buffers read data so RREADY back-pressure never stalls the SRAM bus mid-beat.

## Interface
- ID_W, 4, AXI ID width for AW/B/AR/R
- CLK  in  1  single clock
- RESETn  in  1  reset, synchronous, active-low
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/32/8/3/2  write address channel; AWVALID in 1, AWREADY out 1
- WDATA/WSTRB/WLAST  in  64/8/1  write data; WVALID in 1, WREADY out 1
- BID/BRESP  out  ID_W/2  write response; BVALID out 1, BREADY in 1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/32/8/3/2  read address; ARVALID in 1, ARREADY out 1
- RID/RDATA/RRESP/RLAST  out  ID_W/64/2/1  read data; RVALID out 1, RREADY in 1
- SRAM_CEn  out  1  chip enable, active-low
- SRAM_ADDR  out  32  byte address, bits [2:0] always 0
- SRAM_WDATA  out  64  write data
- SRAM_WEn  out  1  0 = write, 1 = read
- SRAM_WBEn  out  8  byte write enables, active-low (= ~WSTRB)
- SRAM_RDATA  in  64  read data, valid the cycle after a read strobe

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_BURST, RD_DRAIN.
- IDLE: AWREADY/ARREADY asserted only here. If both AWVALID and ARVALID, grant the channel not granted last time (reset: write first). Handshake latches ID, address, LEN, BURST, and error flag; goes to WR_DATA or RD_BURST.
- Error flag: set if ADDR[31:12]!=0 (DECERR) or AxSIZE!=3 or AxBURST is WRAP/reserved (SLVERR). Errored bursts still complete every beat but never assert SRAM_CEn; reads return RDATA=0.
- WR_DATA: WREADY=1. Each W handshake drives SRAM_CEn=0, SRAM_WEn=0, SRAM_ADDR=beat address, SRAM_WDATA=WDATA, SRAM_WBEn=~WSTRB combinationally in that cycle. After LEN+1 beats -> WR_RESP. WLAST early or missing on final beat -> BRESP=SLVERR (beat count governs termination).
- WR_RESP: BVALID=1 with latched BID, BRESP; hold until BREADY; then IDLE.
- RD_BURST: issue one read strobe (CEn=0, WEn=1) per cycle while buffered+in-flight-popped < 2; data captured from SRAM_RDATA into 2-entry buffer the cycle after issue, tagged with RLAST on beat LEN. After last issue -> RD_DRAIN; IDLE when buffer empty and nothing in flight.
- Address: INCR adds 8 per beat, wrapping within 12 bits (no carry into [31:12]); FIXED holds address. Address [2:0] forced to 0.
- Idle SRAM outputs: CEn=1, WEn=1, WBEn=8'hFF, ADDR/WDATA hold last value.

## Timing
- Reset (sync, RESETn=0 at posedge): state IDLE, all VALID/READY outputs 0, SRAM_CEn=1, SRAM_WEn=1, SRAM_WBEn=8'hFF, SRAM_ADDR=0, SRAM_WDATA=0, buffer emptied, in-flight cleared, priority to write. Reset mid-burst abandons it; no B or R emitted afterwards.
- AWREADY/ARREADY high in the first cycle after reset release.
- Write: AW handshake cycle t; first W beat accepted at t+1 earliest; SRAM write in same cycle as W handshake; BVALID cycle after last beat.
- Read: AR handshake t; first strobe t+1; capture t+2; RVALID t+3. With RREADY held high, one beat per cycle thereafter.
- RREADY low: at most one further strobe issues; SRAM bus idles, no data lost, RDATA/RRESP/RLAST stable while RVALID && !RREADY.
- No overlap: next AR/AW accepted only after B handshake or final R handshake.

## Structure
- Package axi_sram_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR/DECERR, state enum, WORD_BYTES=8.
- Sub-module axi_sram_rd_buf: 2-entry FIFO of {RDATA, RLAST}, push/pop/count, synchronous reset.

## Test plan
- Single write AWADDR=0x008, WDATA=0x1122334455667788, WSTRB=0x0F -> one cycle CEn=0, WEn=0, ADDR=0x008, WBEn=0xF0; BRESP=OKAY one cycle after.
- INCR read ARADDR=0x200, ARLEN=3, RREADY=1 -> strobes at 0x200,0x208,0x210,0x218 on consecutive cycles; RVALID first at t+3, 4 beats back-to-back, RLAST on 4th.
- Same read with RREADY toggling 1,0,0,1 -> no beat lost/duplicated, data stable while stalled, ≤2 buffered.
- ARADDR=0x1000, ARLEN=1 -> no SRAM strobe; two beats RDATA=0, RRESP=DECERR; AWBURST=WRAP write -> BRESP=SLVERR, no SRAM write.
- AWVALID and ARVALID together twice from reset -> write granted first, read second; FIXED write LEN=2 at 0x100 -> three writes to 0x100.
- RESETn=0 for one cycle during beat 2 of 4-beat read -> next cycle RVALID=0, CEn=1, ARREADY=1; no stale beats afterwards.
